// File: rtl/nor_gate_bist_pkg.sv
// nor_gate_bist_pkg: shared types and helpers for the NOR gate BIST driver.
//   state_t      - sequencer states
//   NUM_VECTORS  - size of the 2-input truth table swept per pass
//   exp_nor()    - golden NOR value used at the sample point
package nor_gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_VECTORS = 4;

    function automatic logic exp_nor(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// bist_settle_timer: loadable down-counter that flags the last settle cycle.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load cnt with load_val (takes priority over counting)
//   load_val  - reload value; a value of N gives N+1 enabled cycles to tc
//   en        - count enable (held high while the stimulus is settling)
//   tc        - high during the enabled cycle in which the count is zero
module bist_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/nor_gate_bist.sv
// nor_gate_bist: self-checking driver for a 2-input NOR gate under test.
// Sweeps (a,b) = 00,10,01,11 for PASSES sweeps, holds each vector for
// SETTLE_CYCLES, samples dut_y and counts mismatches against ~(a|b).
//   clk, rst          - clock, synchronous active-high reset
//   start             - run request, accepted only in IDLE or DONE
//   dut_a, dut_b      - registered stimulus to the gate
//   dut_y             - gate output under test
//   busy, done, pass  - run status; pass is meaningful while done=1
//   err_count         - saturating mismatch count for the current run
//   first_fail_valid  - a mismatch has been seen this run
//   first_fail_vec    - {b,a} of the first mismatching vector
module nor_gate_bist
    import nor_gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    localparam logic [1:0] LAST_VEC   = 2'(NUM_VECTORS - 1);
    localparam logic [7:0] LAST_SWEEP = 8'(PASSES - 1);
    // Timer reaches zero on the last of the SETTLE_CYCLES settle cycles.
    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] vec;
    logic [7:0] sweep;
    logic       settle_tc;
    logic       mismatch;

    assign mismatch = (state == SAMPLE) && (dut_y != exp_nor(dut_a, dut_b));

    bist_settle_timer #(.W(4)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (state == APPLY),
        .load_val (SETTLE_LD),
        .en       (state == SETTLE),
        .tc       (settle_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            sweep            <= '0;
            dut_a            <= 1'b0;
            dut_b            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    dut_a <= 1'b0;
                    dut_b <= 1'b0;
                    if (start) begin
                        vec              <= '0;
                        sweep            <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
                        state            <= APPLY;
                    end
                end
                APPLY: begin
                    // vec[0] drives a so the order comes out 00,10,01,11 as (a,b)
                    dut_a <= vec[0];
                    dut_b <= vec[1];
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_tc) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + CNT_W'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= {dut_b, dut_a};
                        end
                    end
                    if (vec != LAST_VEC) begin
                        vec   <= vec + 2'd1;
                        state <= APPLY;
                    end else if (sweep < LAST_SWEEP) begin
                        vec   <= '0;
                        sweep <= sweep + 8'd1;
                        state <= APPLY;
                    end else begin
                        // err_count only grows, so it ends at zero only if it
                        // is zero now and this last sample also matched.
                        pass  <= (err_count == '0) && !mismatch;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_gate_bist.sv
// tb_nor_gate_bist: two BIST instances with different parameters, each beside
// a gate modelled as a 4-entry truth table (lut[{b,a}]). Every run pushes the
// expected result into a per-instance queue; monitors pop on each done rise.
module tb_nor_gate_bist;

    localparam int S1 = 2, P1 = 1, W1 = 8;
    localparam int S2 = 1, P2 = 5, W2 = 4;

    typedef struct {
        int         err;
        logic       pass;
        logic       ffv;
        logic [1:0] ffvec;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] lut = 4'b0001;

    logic a1, b1, y1, busy1, done1, pass1, ffv1;
    logic [W1-1:0] err1;
    logic [1:0] ffvec1;
    logic a2, b2, y2, busy2, done2, pass2, ffv2;
    logic [W2-1:0] err2;
    logic [1:0] ffvec2;

    assign y1 = lut[{b1, a1}];
    assign y2 = lut[{b2, a2}];

    always #5 clk = ~clk;

    nor_gate_bist #(.SETTLE_CYCLES(S1), .PASSES(P1), .CNT_W(W1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    nor_gate_bist #(.SETTLE_CYCLES(S2), .PASSES(P2), .CNT_W(W2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .dut_a(a2), .dut_b(b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the truth table in (a,b) order 00,10,01,11 for each
    // pass, count disagreements with NOR, clamp at the counter's maximum.
    function automatic exp_t model(input logic [3:0] l, input int passes,
                                   input int cw, input int sc, input int settle);
        exp_t e;
        e.err = 0; e.ffv = 1'b0; e.ffvec = 2'b00;
        for (int p = 0; p < passes; p++) begin
            for (int idx = 0; idx < 4; idx++) begin
                int a = idx % 2;
                int b = idx / 2;
                int want = (a == 0 && b == 0) ? 1 : 0;
                if (int'(l[idx]) != want) begin
                    if (!e.ffv) begin
                        e.ffv = 1'b1;
                        e.ffvec = 2'(idx);
                    end
                    if (e.err < (1 << cw) - 1) e.err++;
                end
            end
        end
        e.pass = (e.err == 0);
        e.done_cyc = sc + 1 + 4 * passes * (settle + 2);
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e, input int err,
                           input logic ps, input logic fv, input logic [1:0] fvec);
        chk({tag, " err_count"}, err, e.err);
        chk({tag, " pass"}, int'(ps), int'(e.pass));
        chk({tag, " first_fail_valid"}, int'(fv), int'(e.ffv));
        chk({tag, " first_fail_vec"}, int'(fvec), int'(e.ffvec));
        chk({tag, " done cycle"}, cyc, e.done_cyc);
    endtask

    logic done1_q = 1'b0;
    always @(negedge clk) begin
        if (done1 && !done1_q) begin
            if (q1.size() == 0) chk("d1 unexpected done", 1, 0);
            else compare("d1", q1.pop_front(), int'(err1), pass1, ffv1, ffvec1);
        end
        done1_q <= done1;
    end

    logic done2_q = 1'b0;
    always @(negedge clk) begin
        if (done2 && !done2_q) begin
            if (q2.size() == 0) chk("d2 unexpected done", 1, 0);
            else compare("d2", q2.pop_front(), int'(err2), pass2, ffv2, ffvec2);
        end
        done2_q <= done2;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " d1 outputs zero"},
            int'({a1, b1, busy1, done1, pass1, ffv1, ffvec1, err1}), 0);
        chk({tag, " d2 outputs zero"},
            int'({a2, b2, busy2, done2, pass2, ffv2, ffvec2, err2}), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("run timeout", 0, 1);
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic run(input logic [3:0] l, input bit repulse);
        @(negedge clk);
        lut = l;
        start = 1'b1;
        q1.push_back(model(l, P1, W1, cyc, S1));
        q2.push_back(model(l, P2, W2, cyc, S2));
        @(negedge clk);
        start = 1'b0;
        chk("d1 busy after start", int'(busy1), 1);
        chk("d2 busy after start", int'(busy2), 1);
        chk("d1 done cleared", int'(done1), 0);
        if (repulse) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("d1 done held", int'(done1), 1);
        chk("d2 done held", int'(done2), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(4'b0001, 1'b0);   // correct NOR
        run(4'b0000, 1'b1);   // stuck at 0, start re-pulsed mid-run
        run(4'b1111, 1'b0);   // stuck at 1
        run(4'b1110, 1'b0);   // OR gate

        // Abort a run with rst mid-way; no result is expected from it.
        @(negedge clk);
        lut = 4'b1110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("mid-run rst");
        repeat (2) @(negedge clk);
        run(4'b0001, 1'b0);

        for (int i = 0; i < 8; i++) run(4'($urandom_range(0, 15)), 1'b0);

        repeat (5) @(negedge clk);
        chk("leftover expectations", q1.size() + q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout: checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
